// File: rtl/regf_wr_sched_pkg.sv
// Shared constants and phase encoding for the register-file write scheduler.
// READ_PH/WRITE_PH must stay aligned with the RAM wrapper's own phase flop.
package regf_wr_sched_pkg;
  localparam int AW_DEF = 6;
  localparam int DW_DEF = 32;
  localparam int NUM_RD = 4;

  typedef enum logic {
    READ_PH  = 1'b0,
    WRITE_PH = 1'b1
  } phase_e;
endpackage

// File: rtl/regf_wr_bypass.sv
// One read-port bypass: newest matching queued write wins, lane b over lane a.
// Falls back to the raw RAM read data when nothing in the FIFO matches.
module regf_wr_bypass
  import regf_wr_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic [AW-1:0]             rd_addr,
  input  logic [DW-1:0]             ram_data,
  input  logic [DEPTH-1:0][AW-1:0]  ent_addr_a,
  input  logic [DEPTH-1:0][DW-1:0]  ent_data_a,
  input  logic [DEPTH-1:0][AW-1:0]  ent_addr_b,
  input  logic [DEPTH-1:0][DW-1:0]  ent_data_b,
  input  logic [DEPTH-1:0]          ent_vld,
  input  logic [DEPTH-1:0][IW-1:0]  ent_age,
  output logic [DW-1:0]             rd_data
);
  logic          hit;
  logic [IW-1:0] best_age;

  always_comb begin
    rd_data  = ram_data;
    best_age = '0;
    hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_vld[i] && (ent_addr_a[i] == rd_addr || ent_addr_b[i] == rd_addr)
          && (!hit || ent_age[i] > best_age)) begin
        hit      = 1'b1;
        best_age = ent_age[i];
        rd_data  = (ent_addr_b[i] == rd_addr) ? ent_data_b[i] : ent_data_a[i];
      end
    end
  end
endmodule

// File: rtl/regf_wr_fifo.sv
// Write-pair FIFO: DEPTH x {addr_a,data_a,addr_b,data_b}, extra-MSB pointers.
// Exposes the head plus every slot with a valid bit and its age (0 = head, larger = newer).
module regf_wr_fifo
  import regf_wr_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int IW   = $clog2(DEPTH),
  localparam int PW   = IW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [AW-1:0]             push_addr_a,
  input  logic [DW-1:0]             push_data_a,
  input  logic [AW-1:0]             push_addr_b,
  input  logic [DW-1:0]             push_data_b,
  output logic                      full,
  output logic                      empty,
  output logic [AW-1:0]             head_addr_a,
  output logic [DW-1:0]             head_data_a,
  output logic [AW-1:0]             head_addr_b,
  output logic [DW-1:0]             head_data_b,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr_a,
  output logic [DEPTH-1:0][DW-1:0]  ent_data_a,
  output logic [DEPTH-1:0][AW-1:0]  ent_addr_b,
  output logic [DEPTH-1:0][DW-1:0]  ent_data_b,
  output logic [DEPTH-1:0]          ent_vld,
  output logic [DEPTH-1:0][IW-1:0]  ent_age
);
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt, count;
  logic [IW-1:0] wr_idx, rd_idx;

  assign wr_idx = wr_ptr[IW-1:0];
  assign rd_idx = rd_ptr[IW-1:0];
  assign wr_nxt = wr_ptr + PW'(push);
  assign rd_nxt = rd_ptr + PW'(pop);
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);

  // full is registered from the next pointers so o_wr_ready has no input path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= (wr_nxt[IW] != rd_nxt[IW]) && (wr_nxt[IW-1:0] == rd_nxt[IW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr_a[wr_idx] <= push_addr_a;
      ent_data_a[wr_idx] <= push_data_a;
      ent_addr_b[wr_idx] <= push_addr_b;
      ent_data_b[wr_idx] <= push_data_b;
    end
  end

  assign head_addr_a = ent_addr_a[rd_idx];
  assign head_data_a = ent_data_a[rd_idx];
  assign head_addr_b = ent_addr_b[rd_idx];
  assign head_data_b = ent_data_b[rd_idx];

  // age is the distance from the head, so priority survives pointer wrap
  always_comb begin
    ent_age = '0;
    ent_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_age[i] = IW'(i) - rd_idx;
      ent_vld[i] = ({1'b0, ent_age[i]} < count);
    end
  end
endmodule

// File: rtl/regf_wr_sched.sv
// Write-side scheduler for the time-multiplexed 4R/2W register-file RAM on the 2x clock.
// Queues write-back pairs, commits one per WRITE phase, bypasses queued data onto reads.
module regf_wr_sched
  import regf_wr_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic          i_clk_2x,
  input  logic          i_reset_n,
  input  logic          i_wr_valid_a,
  input  logic          i_wr_valid_b,
  input  logic [AW-1:0] i_wr_addr_a,
  input  logic [AW-1:0] i_wr_addr_b,
  input  logic [DW-1:0] i_wr_data_a,
  input  logic [DW-1:0] i_wr_data_b,
  output logic          o_wr_ready,
  output logic          o_phase,
  output logic          o_wen,
  output logic [AW-1:0] o_wr_addr_a,
  output logic [AW-1:0] o_wr_addr_b,
  output logic [DW-1:0] o_wr_data_a,
  output logic [DW-1:0] o_wr_data_b,
  input  logic [AW-1:0] i_rd_addr_a,
  input  logic [AW-1:0] i_rd_addr_b,
  input  logic [AW-1:0] i_rd_addr_c,
  input  logic [AW-1:0] i_rd_addr_d,
  input  logic [DW-1:0] i_ram_rd_data_a,
  input  logic [DW-1:0] i_ram_rd_data_b,
  input  logic [DW-1:0] i_ram_rd_data_c,
  input  logic [DW-1:0] i_ram_rd_data_d,
  output logic [DW-1:0] o_rd_data_a,
  output logic [DW-1:0] o_rd_data_b,
  output logic [DW-1:0] o_rd_data_c,
  output logic [DW-1:0] o_rd_data_d,
  output logic          o_rd_valid
);
  localparam int IW = $clog2(DEPTH);

  phase_e                   phase;
  logic                     rd_vld_q;
  logic                     push, pop, full, empty;
  logic [AW-1:0]            in_addr_a, in_addr_b, head_addr_a, head_addr_b;
  logic [DW-1:0]            in_data_a, in_data_b, head_data_a, head_data_b;
  logic [AW-1:0]            last_addr_a, last_addr_b;
  logic [DW-1:0]            last_data_a, last_data_b;
  logic [DEPTH-1:0][AW-1:0] ent_addr_a, ent_addr_b;
  logic [DEPTH-1:0][DW-1:0] ent_data_a, ent_data_b;
  logic [DEPTH-1:0]         ent_vld;
  logic [DEPTH-1:0][IW-1:0] ent_age;
  logic [NUM_RD-1:0][AW-1:0] rd_addr_in, rd_addr_q;
  logic [NUM_RD-1:0][DW-1:0] ram_data, byp_data;

  always_ff @(posedge i_clk_2x or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase    <= READ_PH;
      rd_vld_q <= 1'b0;
    end else begin
      phase    <= (phase == WRITE_PH) ? READ_PH : WRITE_PH;
      rd_vld_q <= (phase == READ_PH);
    end
  end

  assign o_phase    = phase;
  assign o_rd_valid = rd_vld_q;
  assign o_wr_ready = !full;

  // a single valid lane fills both slots so the RAM sees a consistent pair
  assign push      = (i_wr_valid_a | i_wr_valid_b) & !full;
  assign in_addr_a = i_wr_valid_a ? i_wr_addr_a : i_wr_addr_b;
  assign in_data_a = i_wr_valid_a ? i_wr_data_a : i_wr_data_b;
  assign in_addr_b = i_wr_valid_b ? i_wr_addr_b : i_wr_addr_a;
  assign in_data_b = i_wr_valid_b ? i_wr_data_b : i_wr_data_a;
  assign pop       = (phase == WRITE_PH) && !empty;

  regf_wr_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk         (i_clk_2x),
    .rst_n       (i_reset_n),
    .push        (push),
    .pop         (pop),
    .push_addr_a (in_addr_a),
    .push_data_a (in_data_a),
    .push_addr_b (in_addr_b),
    .push_data_b (in_data_b),
    .full        (full),
    .empty       (empty),
    .head_addr_a (head_addr_a),
    .head_data_a (head_data_a),
    .head_addr_b (head_addr_b),
    .head_data_b (head_data_b),
    .ent_addr_a  (ent_addr_a),
    .ent_data_a  (ent_data_a),
    .ent_addr_b  (ent_addr_b),
    .ent_data_b  (ent_data_b),
    .ent_vld     (ent_vld),
    .ent_age     (ent_age)
  );

  // outputs hold the last committed pair while idle
  always_ff @(posedge i_clk_2x or negedge i_reset_n) begin
    if (!i_reset_n) begin
      last_addr_a <= '0;
      last_addr_b <= '0;
      last_data_a <= '0;
      last_data_b <= '0;
    end else if (pop) begin
      last_addr_a <= head_addr_a;
      last_addr_b <= head_addr_b;
      last_data_a <= head_data_a;
      last_data_b <= head_data_b;
    end
  end

  assign o_wen       = pop;
  assign o_wr_addr_a = pop ? head_addr_a : last_addr_a;
  assign o_wr_addr_b = pop ? head_addr_b : last_addr_b;
  assign o_wr_data_a = pop ? head_data_a : last_data_a;
  assign o_wr_data_b = pop ? head_data_b : last_data_b;

  assign rd_addr_in = {i_rd_addr_d, i_rd_addr_c, i_rd_addr_b, i_rd_addr_a};
  assign ram_data   = {i_ram_rd_data_d, i_ram_rd_data_c, i_ram_rd_data_b, i_ram_rd_data_a};

  always_ff @(posedge i_clk_2x or negedge i_reset_n) begin
    if (!i_reset_n)              rd_addr_q <= '0;
    else if (phase == READ_PH)   rd_addr_q <= rd_addr_in;
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_byp
    regf_wr_bypass #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_byp (
      .rd_addr    (rd_addr_q[g]),
      .ram_data   (ram_data[g]),
      .ent_addr_a (ent_addr_a),
      .ent_data_a (ent_data_a),
      .ent_addr_b (ent_addr_b),
      .ent_data_b (ent_data_b),
      .ent_vld    (ent_vld),
      .ent_age    (ent_age),
      .rd_data    (byp_data[g])
    );
  end

  assign o_rd_data_a = byp_data[0];
  assign o_rd_data_b = byp_data[1];
  assign o_rd_data_c = byp_data[2];
  assign o_rd_data_d = byp_data[3];
endmodule
